// File: rtl/ufp_resp_pkg.sv
// Shared types and defaults for the ufp_responder slice.
// Optional feature macro: UFP_RESPONDER_ALIGN_CHK_EN (see ufp_responder.sv).
package ufp_resp_pkg;

    localparam int DEPTH_DEFAULT   = 256;
    localparam int LATENCY_DEFAULT = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ufp_resp_mem.sv
// DEPTH x 32 word store: byte-enabled synchronous write, combinational read.
module ufp_resp_mem
    import ufp_resp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wmask,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would need DEPTH cycles or a huge reset fan-out, and contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ufp_responder.sv
// Single-outstanding request responder with fixed response latency.
// Define UFP_RESPONDER_ALIGN_CHK_EN to flag and suppress misaligned requests.
module ufp_responder
    import ufp_resp_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ufp_addr,
    input  logic [3:0]  ufp_rmask,
    input  logic [3:0]  ufp_wmask,
    input  logic [31:0] ufp_wdata,
    output logic [31:0] ufp_rdata,
    output logic        ufp_resp,
    output logic        ufp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             rd_q, rd_d;
    logic [3:0]       wmask_q, wmask_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             mis_q, mis_d;

    logic             req_valid;
    logic             req_mis;
    logic             in_resp;
    logic             mem_we;
    logic [31:0]      mem_rdata;
    logic             unused_addr;

    assign req_valid = |(ufp_rmask | ufp_wmask);

`ifdef UFP_RESPONDER_ALIGN_CHK_EN
    assign req_mis = |ufp_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    // Address bits above the word index wrap; byte offset only matters with the align check.
    assign unused_addr = ^{ufp_addr[31:AW+2], ufp_addr[1:0]};

    // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = ufp_addr[AW+1:2];
                    rd_d    = |ufp_rmask;
                    wmask_d = ufp_wmask;
                    wdata_d = ufp_wdata;
                    mis_d   = req_mis;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    assign in_resp = (state_q == RESP);
    assign mem_we  = in_resp && (wmask_q != '0) && !mis_q && !rst;

    // Read port is combinational, so a read+write returns the pre-write word.
    ufp_resp_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .wmask (wmask_q),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    assign ufp_resp  = in_resp;
    assign ufp_err   = in_resp && mis_q;
    assign ufp_rdata = (in_resp && rd_q && !mis_q) ? mem_rdata : '0;

endmodule
